// File: rtl/panda_pkg.sv
// panda_pkg
//   Shared definitions for the execute-stage shift path: RV32I funct3/funct7
//   encodings for the shift group, the occupancy state of the shift stage, and
//   the record held in each pipeline entry.
//   No ports; imported by panda_shift_stage and panda_shifter.
package panda_pkg;

  localparam int WIDTH          = 32;
  localparam int AMOUNT_WIDTH   = $clog2(WIDTH);
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SRx  = 3'b101;
  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_SRA  = 7'b0100000;

  // Entry record used for both the main and the skid entry. An illegal entry
  // still carries rd so that it retires to the right place.
  typedef struct packed {
    logic [WIDTH-1:0]          operand;
    logic [AMOUNT_WIDTH-1:0]   amount;
    logic                      left;
    logic                      arithmetic;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      illegal;
  } shift_op_t;

  // SKID is only reachable when the skid entry is built in.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/panda_shifter.sv
// panda_shifter
//   Purely combinational barrel shifter for the RV32I shift group.
//   Ports:
//     operand    in  Width        value to shift
//     amount     in  AmountWidth  shift distance
//     left       in  1            1 = shift left, 0 = shift right
//     arithmetic in  1            right shifts replicate the sign bit when 1
//     result     out Width        shifted value
module panda_shifter
  import panda_pkg::*;
#(
  parameter int Width       = WIDTH,
  parameter int AmountWidth = $clog2(Width)
) (
  input  logic [Width-1:0]       operand,
  input  logic [AmountWidth-1:0] amount,
  input  logic                   left,
  input  logic                   arithmetic,
  output logic [Width-1:0]       result
);

  always_comb begin
    result = '0;
    if (left) begin
      result = operand << amount;
    end else if (arithmetic) begin
      result = $unsigned($signed(operand) >>> amount);
    end else begin
      result = operand >> amount;
    end
  end

endmodule

// File: rtl/panda_shift_stage.sv
// panda_shift_stage
//   Registered issue/result stage around the shifter. Decodes RV32I shift
//   operations, holds them in a pipeline entry and presents the shifted
//   result, destination register and an illegal-encoding flag downstream.
//   Optional feature macro: PANDA_SHIFT_SKID_EN adds a second (skid) entry and
//   makes in_ready_o purely registered.
//   Ports:
//     clk_i, rst_ni            clock, asynchronous active-low reset
//     flush_i                  synchronous flush, beats accept and retire
//     in_valid_i / in_ready_o  upstream handshake
//     funct3_i, funct7_i       instruction fields selecting the shift kind
//     is_imm_i, imm_i, rs2_i   amount source (immediate or low bits of rs2)
//     rs1_i, rd_i              operand and destination register
//     out_valid_o / out_ready_i downstream handshake
//     result_o, rd_o, illegal_o presented result (result_o is 0 when illegal)
module panda_shift_stage
  import panda_pkg::*;
#(
  parameter int Width        = WIDTH,
  parameter int AmountWidth  = $clog2(Width),
  parameter int RegAddrWidth = REG_ADDR_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [2:0]              funct3_i,
  input  logic [6:0]              funct7_i,
  input  logic                    is_imm_i,
  input  logic [Width-1:0]        rs1_i,
  input  logic [Width-1:0]        rs2_i,
  input  logic [AmountWidth-1:0]  imm_i,
  input  logic [RegAddrWidth-1:0] rd_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [Width-1:0]        result_o,
  output logic [RegAddrWidth-1:0] rd_o,
  output logic                    illegal_o
);

  stage_state_t state;
  shift_op_t    main_q;
`ifdef PANDA_SHIFT_SKID_EN
  shift_op_t    skid_q;
`endif
  shift_op_t    dec_op;
  logic         is_sll;
  logic         is_srl;
  logic         is_sra;
  logic         accept;
  logic         retire;
  logic [Width-1:0] shifted;

  // Shift amounts only use the low bits of rs2; the rest is architecturally ignored.
  logic unused_rs2_high;
  assign unused_rs2_high = ^rs2_i[Width-1:AmountWidth];

  assign is_sll = (funct3_i == FUNCT3_SLL) && (funct7_i == FUNCT7_ZERO);
  assign is_srl = (funct3_i == FUNCT3_SRx) && (funct7_i == FUNCT7_ZERO);
  assign is_sra = (funct3_i == FUNCT3_SRx) && (funct7_i == FUNCT7_SRA);

  always_comb begin
    dec_op            = '0;
    dec_op.operand    = rs1_i;
    dec_op.amount     = is_imm_i ? imm_i : rs2_i[AmountWidth-1:0];
    dec_op.left       = is_sll;
    dec_op.arithmetic = is_sra;
    dec_op.rd         = rd_i;
    dec_op.illegal    = !(is_sll || is_srl || is_sra);
  end

  assign out_valid_o = (state != ST_EMPTY);

`ifdef PANDA_SHIFT_SKID_EN
  // Ready depends only on the state register, breaking the out_ready_i path.
  assign in_ready_o = (state != ST_SKID);
`else
  // A full entry can still accept when it is being drained this same cycle.
  assign in_ready_o = (state == ST_EMPTY) || out_ready_i;
`endif

  assign accept = in_valid_i && in_ready_o;
  assign retire = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_EMPTY;
      main_q <= '0;
`ifdef PANDA_SHIFT_SKID_EN
      skid_q <= '0;
`endif
    end else if (flush_i) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q <= dec_op;
            state  <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && retire) begin
            main_q <= dec_op;
`ifdef PANDA_SHIFT_SKID_EN
          end else if (accept) begin
            skid_q <= dec_op;
            state  <= ST_SKID;
`endif
          end else if (retire) begin
            state <= ST_EMPTY;
          end
        end
        ST_SKID: begin
`ifdef PANDA_SHIFT_SKID_EN
          if (retire) begin
            main_q <= skid_q;
            state  <= ST_FULL;
          end
`else
          state <= ST_EMPTY;
`endif
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  panda_shifter #(
    .Width       (Width),
    .AmountWidth (AmountWidth)
  ) u_shifter (
    .operand    (main_q.operand),
    .amount     (main_q.amount),
    .left       (main_q.left),
    .arithmetic (main_q.arithmetic),
    .result     (shifted)
  );

  assign result_o  = main_q.illegal ? '0 : shifted;
  assign rd_o      = main_q.rd;
  assign illegal_o = main_q.illegal;

endmodule
